hs_serializer: RTL and testbench
================================

Name: hs_serializer

Overview:
- Wide-to-narrow converter placed directly upstream of the codebase's ready/done handshake buffer stage.
- Accepts one wide word from its producer over the four-phase ready/done handshake.
- Emits that word as RATIO narrow beats over the same handshake toward the buffer.
- Input and output handshakes are decoupled; the producer is released without waiting for all beats to drain.

Parameters:
- DATA_BITWIDTH, 8, width of each output beat.
- RATIO, 4, beats per input word; legal range 2..16; input width is DATA_BITWIDTH*RATIO.
- LSB_FIRST, 1, 1 = beat 0 is bits [DATA_BITWIDTH-1:0]; 0 = beat 0 is the most-significant slice.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_BITWIDTH*RATIO  wide word; valid while ready_in=1.
- ready_in  input  1  producer request.
- done_in  output  1  acknowledge to producer.
- data_out  output  DATA_BITWIDTH  current beat.
- ready_out  output  1  request to consumer.
- done_out  input  1  consumer acknowledge.
- busy  output  1  high from capture until the final beat's handshake fully completes.

Behaviour:
- Reset (rst=1 at edge): done_in=0, ready_out=0, busy=0, data_out=0, shift register=0, beat count=0, both FSMs to idle. Applies mid-transfer; the partial word is discarded.
- Protocol, both sides: requester raises ready with data stable; acknowledger raises done; requester drops ready; acknowledger drops done. Data is sampled only on the capture edge.
- Input FSM states: I_IDLE, I_ACK.
- Capture in I_IDLE when ready_in=1, done_in=0, output FSM in O_IDLE. On that edge: shift register <= data_in, done_in <= 1, busy <= 1, beat count <= 0, output FSM -> O_PRESENT, ready_out <= 1, data_out <= beat 0 slice. Latency is 1 cycle from ready_in sampled to done_in and ready_out.
- I_ACK: while ready_in=1, hold done_in=1. At the first edge with ready_in=0, done_in <= 0 and go to I_IDLE. This is independent of output progress.
- No second capture while done_in=1 or output not in O_IDLE. ready_in held high after release is not re-captured until done_in has dropped.
- Output FSM states: O_IDLE, O_PRESENT, O_RELEASE.
- O_PRESENT: ready_out=1, data_out stable. At the edge where done_out=1: ready_out <= 0, go to O_RELEASE.
- O_RELEASE: at the edge where done_out=0:
  - If beat count = RATIO-1: go to O_IDLE, busy <= 0.
  - Otherwise: beat count +1, data_out <= next slice, ready_out <= 1, go to O_PRESENT.
- Minimum beat period is 2 cycles, with done_out toggling every cycle.
- done_out is ignored in O_IDLE. A stuck-high done_out in O_RELEASE stalls indefinitely with no timeout.
- Slice selection: beat k = bits [(k+1)*DATA_BITWIDTH-1 : k*DATA_BITWIDTH] if LSB_FIRST=1; slice RATIO-1-k otherwise.
- Beat count width is clog2(RATIO). The count never wraps past RATIO-1.
- Back-to-back words: capture is allowed on the first edge where output is in O_IDLE. At least one idle cycle separates the last beat's release from the next word's ready_out.
- data_out holds the last beat value in O_IDLE.

Test Plan:
- Reset values: hold rst 3 cycles -> done_in=0, ready_out=0, busy=0, data_out=0x00. Assert ready_in=1 with rst=1 -> no capture.
- Basic serialization (LSB_FIRST=1): data_in=0xA1B2C3D4, ready_in=1, consumer acks every cycle -> done_in=1 one cycle later; beats 0xD4, 0xC3, 0xB2, 0xA1 in order; busy falls after the 4th done_out release.
- MSB order (LSB_FIRST=0): same word -> beats 0xA1, 0xB2, 0xC3, 0xD4.
- Stalls and early release:
  - Producer drops ready_in 2 cycles after done_in -> done_in drops next edge while beats continue.
  - Consumer holds done_out high 5 cycles on beat 1 -> ready_out stays 0, data_out stays 0xC3, no beat skipped.
- Back-to-back and hold: ready_in held high continuously with words 0x11223344 then 0x55667788 -> second word captured only after done_in fell and the prior 4 beats completed. Output is 8 beats, no duplicates, no loss.
- Reset mid-operation: pulse rst during beat 2 with ready_out=1 -> next edge ready_out=0, busy=0, done_in=0, data_out=0. A fresh word afterwards serializes correctly starting at beat 0.

Source files
------------

// File: rtl/hs_serializer.sv
// hs_serializer: wide-to-narrow converter between two four-phase ready/done
// handshakes. A captured DATA_BITWIDTH*RATIO word is emitted as RATIO beats.
// The producer is released independently of how fast the beats drain.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   data_in    wide word, valid while ready_in=1
//   ready_in   producer request
//   done_in    acknowledge to producer (registered)
//   data_out   current narrow beat (registered)
//   ready_out  request to consumer (registered)
//   done_out   consumer acknowledge
//   busy       high from capture until the last beat's handshake completes
module hs_serializer #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned RATIO         = 4,
    parameter bit          LSB_FIRST     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_BITWIDTH*RATIO-1:0]   data_in,
    input  logic                             ready_in,
    output logic                             done_in,
    output logic [DATA_BITWIDTH-1:0]         data_out,
    output logic                             ready_out,
    input  logic                             done_out,
    output logic                             busy
);

    localparam int unsigned WIDE_W = DATA_BITWIDTH * RATIO;
    localparam int unsigned CNT_W  = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    // Input-side FSM encoding
    localparam logic [0:0] I_IDLE = 1'b0;
    localparam logic [0:0] I_ACK  = 1'b1;

    // Output-side FSM encoding
    localparam logic [1:0] O_IDLE    = 2'd0;
    localparam logic [1:0] O_PRESENT = 2'd1;
    localparam logic [1:0] O_RELEASE = 2'd2;

    logic [0:0]               i_state;
    logic [0:0]               i_state_nxt;
    logic [1:0]               o_state;
    logic [1:0]               o_state_nxt;
    logic [WIDE_W-1:0]        shift_reg;
    logic [WIDE_W-1:0]        shift_reg_nxt;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         beat_cnt_nxt;
    logic                     done_in_nxt;
    logic                     ready_out_nxt;
    logic                     busy_nxt;
    logic [DATA_BITWIDTH-1:0] data_out_nxt;
    logic                     capture_c;

    // Beat k of a word; beat order depends on LSB_FIRST.
    function automatic logic [DATA_BITWIDTH-1:0] pick_slice(
        input logic [WIDE_W-1:0] word,
        input logic [CNT_W-1:0]  k
    );
        logic [CNT_W-1:0] idx;
        int unsigned      base;
        idx  = LSB_FIRST ? k : (LAST_BEAT - k);
        base = 32'(idx) * DATA_BITWIDTH;
        return word[base +: DATA_BITWIDTH];
    endfunction

    // A new word is taken only when both sides are idle, so a producer that
    // keeps ready_in high is not re-captured until done_in has dropped.
    assign capture_c = (i_state == I_IDLE) && ready_in && !done_in &&
                       (o_state == O_IDLE);

    // Input handshake next-state: acknowledge, then wait for ready_in to drop.
    always_comb begin
        i_state_nxt = i_state;
        done_in_nxt = done_in;
        case (i_state)
            I_IDLE: begin
                if (capture_c) begin
                    i_state_nxt = I_ACK;
                    done_in_nxt = 1'b1;
                end
            end
            I_ACK: begin
                if (!ready_in) begin
                    i_state_nxt = I_IDLE;
                    done_in_nxt = 1'b0;
                end
            end
            default: begin
                i_state_nxt = I_IDLE;
                done_in_nxt = 1'b0;
            end
        endcase
    end

    // Output handshake next-state: present a beat, wait for the full
    // done_out pulse, then advance or finish.
    always_comb begin
        o_state_nxt   = o_state;
        shift_reg_nxt = shift_reg;
        beat_cnt_nxt  = beat_cnt;
        ready_out_nxt = ready_out;
        busy_nxt      = busy;
        data_out_nxt  = data_out;
        case (o_state)
            O_IDLE: begin
                if (capture_c) begin
                    shift_reg_nxt = data_in;
                    beat_cnt_nxt  = '0;
                    busy_nxt      = 1'b1;
                    ready_out_nxt = 1'b1;
                    data_out_nxt  = pick_slice(data_in, '0);
                    o_state_nxt   = O_PRESENT;
                end
            end
            O_PRESENT: begin
                if (done_out) begin
                    ready_out_nxt = 1'b0;
                    o_state_nxt   = O_RELEASE;
                end
            end
            O_RELEASE: begin
                // A stuck-high done_out stalls here indefinitely.
                if (!done_out) begin
                    if (beat_cnt == LAST_BEAT) begin
                        busy_nxt    = 1'b0;
                        o_state_nxt = O_IDLE;
                    end else begin
                        beat_cnt_nxt  = beat_cnt + CNT_W'(1);
                        data_out_nxt  = pick_slice(shift_reg, beat_cnt + CNT_W'(1));
                        ready_out_nxt = 1'b1;
                        o_state_nxt   = O_PRESENT;
                    end
                end
            end
            default: begin
                ready_out_nxt = 1'b0;
                busy_nxt      = 1'b0;
                o_state_nxt   = O_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state   <= I_IDLE;
            o_state   <= O_IDLE;
            shift_reg <= '0;
            beat_cnt  <= '0;
            done_in   <= 1'b0;
            ready_out <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
        end else begin
            i_state   <= i_state_nxt;
            o_state   <= o_state_nxt;
            shift_reg <= shift_reg_nxt;
            beat_cnt  <= beat_cnt_nxt;
            done_in   <= done_in_nxt;
            ready_out <= ready_out_nxt;
            busy      <= busy_nxt;
            data_out  <= data_out_nxt;
        end
    end

endmodule

// File: tb/tb_hs_serializer.sv
// Directed bench for hs_serializer: an LSB-first and an MSB-first instance
// share all inputs, so each step checks both beat orders at once.
module tb_hs_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        ready_in;
    logic        done_out;

    logic        done_in_l, ready_out_l, busy_l;
    logic [7:0]  data_out_l;
    logic        done_in_m, ready_out_m, busy_m;
    logic [7:0]  data_out_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hs_serializer #(.DATA_BITWIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .ready_in(ready_in),
        .done_in(done_in_l), .data_out(data_out_l), .ready_out(ready_out_l),
        .done_out(done_out), .busy(busy_l)
    );

    hs_serializer #(.DATA_BITWIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .ready_in(ready_in),
        .done_in(done_in_m), .data_out(data_out_m), .ready_out(ready_out_m),
        .done_out(done_out), .busy(busy_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise ready_in with a word and check the one-cycle capture response.
    task automatic start_word(input logic [31:0] w, input logic [7:0] b0_l, input logic [7:0] b0_m);
        data_in  = w;
        ready_in = 1'b1;
        @(negedge clk);
        chk("cap_done_in", done_in_l, 1);
        chk("cap_ready_out", ready_out_l, 1);
        chk("cap_busy", busy_l, 1);
        chk("cap_beat0_lsb", data_out_l, b0_l);
        chk("cap_beat0_msb", data_out_m, b0_m);
        chk("cap_msb_ctrl", {done_in_m, ready_out_m, busy_m}, 3'b111);
    endtask

    // Wait for a beat, check it, then hold done_out high for 'hold' cycles.
    task automatic present(input logic [7:0] exp_l, input logic [7:0] exp_m, input int hold);
        int waited = 0;
        while (ready_out_l !== 1'b1 && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", ready_out_l, 1);
        chk("beat_lsb", data_out_l, exp_l);
        chk("beat_msb", data_out_m, exp_m);
        done_out = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("ack_ready_low", ready_out_l, 0);
            chk("ack_data_hold", data_out_l, exp_l);
        end
    endtask

    task automatic release_beat();
        done_out = 1'b0;
        @(negedge clk);
    endtask

    task automatic take(input logic [7:0] exp_l, input logic [7:0] exp_m);
        present(exp_l, exp_m, 1);
        release_beat();
    endtask

    initial begin
        // Reset, with a request pending that must not be captured
        rst      = 1'b1;
        ready_in = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        done_out = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done_in", done_in_l, 0);
        chk("rst_ready_out", ready_out_l, 0);
        chk("rst_busy", busy_l, 0);
        chk("rst_data_lsb", data_out_l, 8'h00);
        chk("rst_data_msb", data_out_m, 8'h00);
        rst      = 1'b0;
        ready_in = 1'b0;
        @(negedge clk);
        chk("idle_done_in", done_in_l, 0);

        // Basic serialization, consumer acks every cycle
        start_word(32'hA1B2C3D4, 8'hD4, 8'hA1);
        ready_in = 1'b0;
        take(8'hD4, 8'hA1);
        chk("basic_done_in_low", done_in_l, 0);
        take(8'hC3, 8'hB2);
        take(8'hB2, 8'hC3);
        chk("basic_busy_mid", busy_l, 1);
        take(8'hA1, 8'hD4);
        chk("basic_busy_end", busy_l, 0);
        chk("basic_msb_busy_end", busy_m, 0);
        chk("basic_hold_lsb", data_out_l, 8'hA1);
        chk("basic_hold_msb", data_out_m, 8'hD4);
        @(negedge clk);

        // Late producer release and a long consumer stall on beat 1
        start_word(32'hA1B2C3D4, 8'hD4, 8'hA1);
        take(8'hD4, 8'hA1);
        chk("late_done_in_held", done_in_l, 1);
        ready_in = 1'b0;
        @(negedge clk);
        chk("late_done_in_drop", done_in_l, 0);
        chk("late_busy", busy_l, 1);
        present(8'hC3, 8'hB2, 5);
        release_beat();
        take(8'hB2, 8'hC3);
        take(8'hA1, 8'hD4);
        chk("stall_busy_end", busy_l, 0);
        @(negedge clk);

        // Back-to-back words with ready_in re-raised right after release
        start_word(32'h11223344, 8'h44, 8'h11);
        ready_in = 1'b0;
        present(8'h44, 8'h11, 1);
        data_in  = 32'h55667788;
        ready_in = 1'b1;
        release_beat();
        take(8'h33, 8'h22);
        chk("b2b_no_recapture", done_in_l, 0);
        take(8'h22, 8'h33);
        take(8'h11, 8'h44);
        chk("b2b_gap_done_in", done_in_l, 0);
        chk("b2b_gap_ready_out", ready_out_l, 0);
        chk("b2b_gap_busy", busy_l, 0);
        @(negedge clk);
        chk("b2b_cap_done_in", done_in_l, 1);
        chk("b2b_cap_ready_out", ready_out_l, 1);
        chk("b2b_cap_busy", busy_l, 1);
        ready_in = 1'b0;
        take(8'h88, 8'h55);
        take(8'h77, 8'h66);
        take(8'h66, 8'h77);
        take(8'h55, 8'h88);
        chk("b2b_busy_end", busy_l, 0);
        @(negedge clk);

        // Reset while beat 2 is presented, then a fresh word
        start_word(32'hDEADBEEF, 8'hEF, 8'hDE);
        take(8'hEF, 8'hDE);
        take(8'hBE, 8'hAD);
        chk("mid_ready_out", ready_out_l, 1);
        chk("mid_beat2_lsb", data_out_l, 8'hAD);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_out", ready_out_l, 0);
        chk("mid_rst_busy", busy_l, 0);
        chk("mid_rst_done_in", done_in_l, 0);
        chk("mid_rst_data_lsb", data_out_l, 8'h00);
        chk("mid_rst_data_msb", data_out_m, 8'h00);
        rst      = 1'b0;
        ready_in = 1'b0;
        @(negedge clk);
        start_word(32'h0BADF00D, 8'h0D, 8'h0B);
        ready_in = 1'b0;
        take(8'h0D, 8'h0B);
        take(8'hF0, 8'hAD);
        take(8'hAD, 8'hF0);
        take(8'h0B, 8'h0D);
        chk("post_rst_busy_end", busy_l, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
